seq_comparator_32b: RTL

SEQ_COMPARATOR_32B -- requirements
Module: seq_comparator_32b

---
 rtl/seq_comparator_32b_pkg.sv | 22 ++
 rtl/seq_comparator_32b_cmp8.sv | 22 ++
 rtl/seq_comparator_32b.sv | 114 +++++++++++
 3 files changed

// File: rtl/seq_comparator_32b_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_comparator_32b_pkg                                               |
// | Shared constants and state encoding for the byte-serial comparator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seq_comparator_32b_pkg;

  localparam int C_OPERAND_W = 32;
  localparam int C_SLICE_W   = 8;
  localparam int C_BEATS     = 4;
  localparam int C_IDX_W     = 2;

  localparam logic [C_IDX_W-1:0] C_IDX_TOP = C_IDX_W'(C_BEATS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

endpackage : seq_comparator_32b_pkg
`default_nettype wire

// File: rtl/seq_comparator_32b_cmp8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_8b                                                        |
// | Combinational unsigned magnitude compare of one byte slice.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module comparator_8b
  import seq_comparator_32b_pkg::*;
(
  input  logic [C_SLICE_W-1:0] i_a,
  input  logic [C_SLICE_W-1:0] i_b,
  output logic                 o_eq,
  output logic                 o_lt,
  output logic                 o_gt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);
  assign o_gt = (i_a >  i_b);

endmodule : comparator_8b
`default_nettype wire

// File: rtl/seq_comparator_32b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_comparator_32b                                                   |
// | Byte-serial 32-bit signed/unsigned comparator, MSB byte first with   |
// | early exit on the first differing byte.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_comparator_32b
  import seq_comparator_32b_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [C_OPERAND_W-1:0] x,
  input  logic [C_OPERAND_W-1:0] y,
  input  logic                   is_signed,
  output logic                   busy,
  output logic                   done,
  output logic                   eq,
  output logic                   lt,
  output logic                   gt
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [C_OPERAND_W-1:0] r_a;
  logic [C_OPERAND_W-1:0] r_b;
  logic [C_IDX_W-1:0]     r_idx;
  logic                   r_done;
  logic                   r_eq;
  logic                   r_lt;
  logic                   r_gt;

  logic [C_SLICE_W-1:0]   w_a_slice;
  logic [C_SLICE_W-1:0]   w_b_slice;
  logic                   w_slice_eq;
  logic                   w_slice_lt;
  logic                   w_slice_gt;
  logic                   w_accept;
  logic [C_OPERAND_W-1:0] w_sign_flip;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_sign_flip = {is_signed, {(C_OPERAND_W-1){1'b0}}};
  assign w_accept    = (r_state == IDLE) && start;

  assign w_a_slice = r_a[{r_idx, 3'b000} +: C_SLICE_W];
  assign w_b_slice = r_b[{r_idx, 3'b000} +: C_SLICE_W];

  comparator_8b u_cmp8 (
    .i_a  (w_a_slice),
    .i_b  (w_b_slice),
    .o_eq (w_slice_eq),
    .o_lt (w_slice_lt),
    .o_gt (w_slice_gt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CMP;
      CMP:     if (!w_slice_eq || (r_idx == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= C_IDX_TOP;
      r_done <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
      r_gt   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a   <= x ^ w_sign_flip;
        r_b   <= y ^ w_sign_flip;
        r_idx <= C_IDX_TOP;
      end else if (r_state == CMP) begin
        if (!w_slice_eq) begin
          r_eq   <= 1'b0;
          r_lt   <= w_slice_lt;
          r_gt   <= w_slice_gt;
          r_done <= 1'b1;
        end else if (r_idx != '0) begin
          r_idx <= r_idx - 1'b1;
        end else begin
          r_eq   <= 1'b1;
          r_lt   <= 1'b0;
          r_gt   <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == CMP);
  assign done = r_done;
  assign eq   = r_eq;
  assign lt   = r_lt;
  assign gt   = r_gt;

endmodule : seq_comparator_32b
`default_nettype wire
